// File: rtl/peak_packer.sv
// Keeps the strongest PEAK_NUM peaks per point and emits one addressed packed word per point.
// Word valid two cycles after the last beat; one peak_ready bubble per point; FLUSH waits while the output word is held.
module peak_packer #(
    parameter int SIGNAL_WIDTH = 18,
    parameter int DIST_WIDTH   = 14,
    parameter int PEAK_NUM     = 4,
    parameter int DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
    parameter int ADDR_WIDTH   = 16,
    parameter int CNT_WIDTH    = $clog2(PEAK_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    peak_valid,
    output logic                    peak_ready,
    input  logic [DIST_WIDTH-1:0]   peak_dist,
    input  logic [SIGNAL_WIDTH-1:0] peak_signal,
    input  logic                    peak_null,
    input  logic                    peak_last,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [CNT_WIDTH-1:0]    mem_count,
    output logic                    mem_overflow
);

    localparam int SLOT_W = SIGNAL_WIDTH + DIST_WIDTH;
    localparam int IDX_W  = (PEAK_NUM > 1) ? $clog2(PEAK_NUM) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PEAK_NUM);

    typedef enum logic {COLLECT, FLUSH} state_t;

    state_t                  state_q;
    logic [SIGNAL_WIDTH-1:0] sig_q  [PEAK_NUM];
    logic [DIST_WIDTH-1:0]   dist_q [PEAK_NUM];
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    ovf_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;

    logic                    mem_valid_q;
    logic [DATA_WIDTH-1:0]   mem_data_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [CNT_WIDTH-1:0]    mem_count_q;
    logic                    mem_overflow_q;

    logic [IDX_W-1:0]        min_idx;
    logic [SIGNAL_WIDTH-1:0] min_sig;
    logic [DATA_WIDTH-1:0]   packed_d;
    logic                    out_free;

    // Lowest index wins on ties because only a strictly smaller value moves the pick.
    always_comb begin
        min_idx = '0;
        min_sig = sig_q[0];
        for (int i = 1; i < PEAK_NUM; i++) begin
            if (sig_q[i] < min_sig) begin
                min_sig = sig_q[i];
                min_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        packed_d = '0;
        for (int i = 0; i < PEAK_NUM; i++) begin
            packed_d[i*SLOT_W +: DIST_WIDTH]                = dist_q[i];
            packed_d[i*SLOT_W + DIST_WIDTH +: SIGNAL_WIDTH] = sig_q[i];
        end
    end

    assign out_free   = !mem_valid_q || mem_ready;
    assign peak_ready = (state_q == COLLECT) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= COLLECT;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            next_addr_q    <= '0;
            mem_valid_q    <= 1'b0;
            mem_data_q     <= '0;
            mem_addr_q     <= '0;
            mem_count_q    <= '0;
            mem_overflow_q <= 1'b0;
            for (int i = 0; i < PEAK_NUM; i++) begin
                sig_q[i]  <= '0;
                dist_q[i] <= '0;
            end
        end else begin
            if (mem_valid_q && mem_ready) begin
                mem_valid_q <= 1'b0;
            end
            case (state_q)
                COLLECT: begin
                    if (peak_valid) begin
                        if (!peak_null) begin
                            if (cnt_q < FULL_CNT) begin
                                sig_q[cnt_q[IDX_W-1:0]]  <= peak_signal;
                                dist_q[cnt_q[IDX_W-1:0]] <= peak_dist;
                                cnt_q                    <= cnt_q + CNT_WIDTH'(1);
                            end else begin
                                ovf_q <= 1'b1;
                                if (peak_signal > min_sig) begin
                                    sig_q[min_idx]  <= peak_signal;
                                    dist_q[min_idx] <= peak_dist;
                                end
                            end
                        end
                        if (peak_last) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        mem_valid_q    <= 1'b1;
                        mem_data_q     <= packed_d;
                        mem_addr_q     <= next_addr_q;
                        mem_count_q    <= cnt_q;
                        mem_overflow_q <= ovf_q;
                        next_addr_q    <= next_addr_q + ADDR_WIDTH'(1);
                        cnt_q          <= '0;
                        ovf_q          <= 1'b0;
                        state_q        <= COLLECT;
                        for (int i = 0; i < PEAK_NUM; i++) begin
                            sig_q[i]  <= '0;
                            dist_q[i] <= '0;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
            // A coincident load still takes the old address; the restart wins for the next word.
            if (frame_start) begin
                next_addr_q <= '0;
            end
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_data     = mem_data_q;
    assign mem_addr     = mem_addr_q;
    assign mem_count    = mem_count_q;
    assign mem_overflow = mem_overflow_q;

endmodule

// File: tb/tb_peak_packer.sv
// Scoreboard bench for peak_packer: drivers push model-predicted words, a negedge monitor pops and compares.
module tb_peak_packer;

    localparam int S  = 18;
    localparam int D  = 14;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = (S + D) * N;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          peak_valid;
    logic          peak_ready;
    logic [D-1:0]  peak_dist;
    logic [S-1:0]  peak_signal;
    logic          peak_null;
    logic          peak_last;
    logic          mem_valid;
    logic          mem_ready;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_count;
    logic          mem_overflow;

    peak_packer #(
        .SIGNAL_WIDTH(S), .DIST_WIDTH(D), .PEAK_NUM(N), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .peak_valid(peak_valid), .peak_ready(peak_ready),
        .peak_dist(peak_dist), .peak_signal(peak_signal),
        .peak_null(peak_null), .peak_last(peak_last),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_count(mem_count), .mem_overflow(mem_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned d;
        int unsigned s;
        bit          nul;
        bit          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t  sb[$];
    int    n_chk    = 0;
    int    n_err    = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int    exp_addr = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic beat_t mk(input int unsigned d, input int unsigned s, input bit nul, input bit last);
        beat_t b;
        b.d = d; b.s = s; b.nul = nul; b.last = last;
        return b;
    endfunction

    // Keep the first N peaks in arrival order; afterwards a stronger peak evicts the weakest (first one on ties).
    function automatic exp_t model(input beat_t bs[$], input int addr);
        int unsigned ss[N];
        int unsigned dd[N];
        int          n;
        int          m;
        exp_t        e;
        n = 0;
        e.data = '0;
        e.ovf  = 1'b0;
        for (int i = 0; i < N; i++) begin
            ss[i] = 0;
            dd[i] = 0;
        end
        foreach (bs[k]) begin
            if (!bs[k].nul) begin
                if (n < N) begin
                    ss[n] = bs[k].s;
                    dd[n] = bs[k].d;
                    n++;
                end else begin
                    e.ovf = 1'b1;
                    m = 0;
                    for (int i = 1; i < N; i++) if (ss[i] < ss[m]) m = i;
                    if (bs[k].s > ss[m]) begin
                        ss[m] = bs[k].s;
                        dd[m] = bs[k].d;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            e.data[i*(S+D) +: D]     = D'(dd[i]);
            e.data[i*(S+D) + D +: S] = S'(ss[i]);
        end
        e.cnt  = CW'(n);
        e.addr = AW'(addr);
        return e;
    endfunction

    task automatic send_beat(input beat_t b);
        bit acc;
        acc         = 1'b0;
        peak_valid  = 1'b1;
        peak_dist   = D'(b.d);
        peak_signal = S'(b.s);
        peak_null   = b.nul;
        peak_last   = b.last;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = peak_ready;
            @(posedge clk);
            #1;
        end
        peak_valid = 1'b0;
        peak_null  = 1'b0;
        peak_last  = 1'b0;
        check("beat_accept", acc, 1);
    endtask

    task automatic send_point(input beat_t bs[$], input bit gaps);
        foreach (bs[k]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (bs[k].last) begin
                sb.push_back(model(bs, exp_addr));
                exp_addr = (exp_addr + 1) % (1 << AW);
            end
            send_beat(bs[k]);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 1000 && (sb.size() != 0 || mem_valid); c++) @(negedge clk);
        check("drain", (sb.size() == 0 && !mem_valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic simple_point(input int np);
        beat_t bs[$];
        for (int i = 0; i < np; i++)
            bs.push_back(mk($urandom_range(0, 16383), $urandom_range(0, 262143), 0, i == np - 1));
        if (np == 0) bs.push_back(mk(0, 0, 1, 1));
        send_point(bs, 0);
    endtask

    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       mem_ready = 1'b1;
                2:       mem_ready = 1'b0;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops on every handshake and verifies held words do not change.
    exp_t          e_mon;
    bit            held = 1'b0;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_addr;
    logic [CW-1:0] h_cnt;
    logic          h_ovf;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", mem_valid, 1);
                check("hold_data", mem_data, h_data);
                check("hold_addr", mem_addr, h_addr);
                check("hold_count", mem_count, h_cnt);
                check("hold_ovf", mem_overflow, h_ovf);
            end
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    check("word_data", mem_data, e_mon.data);
                    check("word_addr", mem_addr, e_mon.addr);
                    check("word_count", mem_count, e_mon.cnt);
                    check("word_ovf", mem_overflow, e_mon.ovf);
                end
            end
            held   = mem_valid && !mem_ready;
            h_data = mem_data;
            h_addr = mem_addr;
            h_cnt  = mem_count;
            h_ovf  = mem_overflow;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        beat_t bs[$];
        int    np;
        rst         = 1'b1;
        frame_start = 1'b0;
        peak_valid  = 1'b0;
        peak_dist   = '0;
        peak_signal = '0;
        peak_null   = 1'b0;
        peak_last   = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_peak_ready", peak_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_count", mem_count, 0);
        check("rst_mem_ovf", mem_overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", peak_ready, 1);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_addr = 0;

        // Basic point plus latency
        bs = {mk(100, 25000, 0, 0), mk(200, 500, 0, 0), mk(300, 21000, 0, 1)};
        send_point(bs, 0);
        @(negedge clk);
        check("latency_t1", mem_valid, 0);
        @(negedge clk);
        check("latency_t2", mem_valid, 1);
        @(posedge clk); #1;

        // Overflow with replacement, then a tie that must be dropped, then an empty point
        bs = {mk(1, 10, 0, 0), mk(2, 50, 0, 0), mk(3, 30, 0, 0), mk(4, 40, 0, 0), mk(5, 60, 0, 0), mk(6, 5, 0, 1)};
        send_point(bs, 0);
        bs = {mk(1, 10, 0, 0), mk(2, 50, 0, 0), mk(3, 30, 0, 0), mk(4, 40, 0, 0), mk(9, 10, 0, 1)};
        send_point(bs, 0);
        bs = {mk(0, 0, 1, 1)};
        send_point(bs, 0);
        bs = {mk(7, 70, 0, 0), mk(0, 0, 1, 0), mk(8, 80, 0, 0), mk(0, 0, 1, 1)};
        send_point(bs, 0);
        wait_drain();

        // Backpressure: one word held, second point stuck in FLUSH
        rdy_mode = 2;
        @(posedge clk); #1;
        simple_point(2);
        simple_point(1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("flush_ready_low", peak_ready, 0);
            check("stall_valid", mem_valid, 1);
        end
        rdy_mode = 0;
        begin
            bit hs;
            hs = 1'b0;
            for (int c = 0; c < 50 && !hs; c++) begin
                @(negedge clk);
                hs = mem_valid && mem_ready;
            end
            check("release_handshake", hs, 1);
            @(negedge clk);
            check("back_to_back", mem_valid, 1);
        end
        wait_drain();

        // Address wrap over five points after a restart
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_addr = 0;
        for (int p = 0; p < 5; p++) simple_point(p % 3);
        wait_drain();

        // frame_start coinciding with the output load
        simple_point(2);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_addr = 0;
        simple_point(3);
        wait_drain();

        // Reset in the middle of a point
        send_beat(mk(11, 111, 0, 0));
        send_beat(mk(22, 222, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", peak_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_valid", mem_valid, 0);
        check("midrst_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr = 0;
        bs = {mk(33, 333, 0, 1)};
        send_point(bs, 0);
        wait_drain();

        // Randomized points with random output backpressure
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            bs = {};
            np = $urandom_range(0, 7);
            for (int i = 0; i < np; i++) begin
                if ($urandom_range(0, 7) == 0) bs.push_back(mk(0, 0, 1, 0));
                bs.push_back(mk($urandom_range(0, 16383),
                                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 262143),
                                0, 0));
            end
            if (np == 0 || $urandom_range(0, 3) == 0) bs.push_back(mk(0, 0, 1, 1));
            else bs[bs.size() - 1].last = 1'b1;
            send_point(bs, 1);
        end
        rdy_mode = 0;
        wait_drain();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/peak_packer.md
Name: peak_packer

Overview:
- Writer-side counterpart of the peak-classification core.
- Receives a per-point stream of detected peaks (distance, signal amplitude) and keeps the strongest PEAK_NUM peaks of each point.
- Packs them into the memory word format that the classification core reads, and issues one addressed memory write per point over a valid/ready interface.
- Sits between the peak detector and the point-cloud memory.

Parameters:
- SIGNAL_WIDTH, 18, signal amplitude width per peak.
- DIST_WIDTH, 14, distance width per peak.
- PEAK_NUM, 4, peak slots per memory word.
- DATA_WIDTH, (SIGNAL_WIDTH+DIST_WIDTH)*PEAK_NUM, packed word width.
- ADDR_WIDTH, 16, memory word address width.
- CNT_WIDTH, $clog2(PEAK_NUM+1), slot-count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; restarts write addressing at 0.
- peak_valid  in  1  input beat valid.
- peak_ready  out  1  input beat accepted when peak_valid & peak_ready.
- peak_dist  in  DIST_WIDTH  peak distance.
- peak_signal  in  SIGNAL_WIDTH  peak amplitude.
- peak_null  in  1  beat carries no peak (used to close an empty point).
- peak_last  in  1  final beat of the current point.
- mem_valid  out  1  output word valid.
- mem_ready  in  1  memory accepts word.
- mem_data  out  DATA_WIDTH  packed word.
- mem_addr  out  ADDR_WIDTH  write address of mem_data.
- mem_count  out  CNT_WIDTH  number of occupied slots in mem_data.
- mem_overflow  out  1  more than PEAK_NUM real peaks were received for this point.

Behaviour:
- Packing: slot i occupies bits [i*(S+D)+S+D-1 : i*(S+D)+D] for signal and [i*(S+D)+D-1 : i*(S+D)] for distance (S=SIGNAL_WIDTH, D=DIST_WIDTH). Unused slots are all-zero. Slots fill in arrival order starting at slot 0.
- State machine, two states:
  - COLLECT: peak_ready=1.
  - FLUSH: peak_ready=0.
- Beat accepted in COLLECT with peak_null=0:
  - If count<PEAK_NUM: write slot[count], count++.
  - Otherwise set the overflow flag. If peak_signal > min slot signal (strictly greater), replace the lowest-index slot holding the minimum (both signal and distance). If not, drop the beat.
- Beat with peak_null=1: no slot change. If peak_last=1 it still closes the point.
- An accepted peak_last beat is folded into the assembly first, then the state moves to FLUSH.
- FLUSH, when the output register is free (mem_valid==0 | mem_ready):
  - Load mem_data, mem_count, mem_overflow and mem_addr←next_addr.
  - Set mem_valid, clear the assembly (slots, count, overflow), return to COLLECT.
- FLUSH while the output register is held: stay in FLUSH.
- Latency: last beat accepted in cycle t → mem_valid=1 from cycle t+2 if the output register is free. Each point costs one bubble cycle on peak_ready.
- Output hold: mem_valid stays 1 and mem_data/mem_addr/mem_count/mem_overflow stay stable until the mem_valid&mem_ready handshake.
- A handshake and a FLUSH load in the same cycle are legal and give back-to-back words with no gap.
- next_addr:
  - Increments by 1 at each output load; wraps 2^ADDR_WIDTH-1 → 0.
  - frame_start sets next_addr=0. If a load coincides, the loaded word takes the old next_addr and next_addr becomes 0.
  - frame_start never alters the assembly or the output register.
- Beats with peak_valid=1 while peak_ready=0 are not consumed; the source holds them.
- rst (synchronous):
  - Outputs: mem_valid=0, mem_data=0, mem_addr=0, mem_count=0, mem_overflow=0, peak_ready=0 during rst, then 1 in COLLECT.
  - Internal: state=COLLECT, next_addr=0, assembly cleared.
  - A word or point in progress is discarded.
- No arithmetic widening: comparisons are unsigned on SIGNAL_WIDTH.

Test Plan:
- Basic: after reset, frame_start; point beats (100,25000), (200,500), (300,21000) with last on the third, mem_ready=1 → at t+2 mem_valid=1, mem_addr=0, mem_count=3, slot0=(25000,100), slot1=(500,200), slot2=(21000,300), slot3=0, mem_overflow=0.
- Overflow: 6 peaks with signals 10,50,30,40,60,5 → slot0=60, slot1=50, slot2=30, slot3=40 (distances follow their signals), mem_count=4, mem_overflow=1. Tie case: 5th signal equal to the min is dropped.
- Empty point: a single beat with peak_null=1, last=1 → mem_data=0, mem_count=0, mem_addr incremented from the previous word.
- Backpressure: mem_ready=0 for 10 cycles with a word pending; the next point completes → state holds FLUSH, peak_ready=0, mem_data stable. On release, words go out back-to-back at consecutive addresses.
- Address wrap and frame_start: ADDR_WIDTH=2, 5 points → addresses 0,1,2,3,0. frame_start coincident with a load → that word keeps its old address, next word at 0.
- Reset mid-point: 2 beats accepted, then rst → mem_valid=0, mem_addr=0. The next point packs only its own beats.
